multi_wave_oscillator: RTL and testbench

- Parametrised phase-accumulator oscillator for the synth voice path; generalises the fixed-width triangle generator.
- Selectable triangle, sawtooth, variable-width pulse and LFSR noise output, produced as signed samples with volume scaling.
- Frequency and mode updates are staged and applied only at a period boundary, so note and waveform changes never glitch mid-cycle.
- Sits between the MIDI note decoder (which supplies freq_word, mode and volume) and the voice mixer.

---
 rtl/synth_pkg.sv | 16 +
 rtl/multi_wave_oscillator_lfsr.sv | 25 ++
 rtl/multi_wave_oscillator.sv | 118 +++++++++++
 tb/tb_multi_wave_oscillator.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice oscillators: waveform selector and
// noise generator constants.
package synth_pkg;

   typedef enum logic [1:0] {
      SAW   = 2'd0,
      TRI   = 2'd1,
      PULSE = 2'd2,
      NOISE = 2'd3
   } wave_mode_t;

   // Feedback taps at bits 15, 13, 12 and 10 give a maximal-length sequence
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/multi_wave_oscillator_lfsr.sv
// 16-bit Fibonacci LFSR noise source that advances once per oscillator period.
module wave_lfsr16
   import synth_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        step,
   output logic [15:0] out
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (step) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign out = lfsr_q;

endmodule

// File: rtl/multi_wave_oscillator.sv
// Phase-accumulator oscillator with saw/triangle/pulse/noise outputs, volume
// scaling, and note/mode changes deferred to the next period boundary.
module multi_wave_oscillator
   import synth_pkg::*;
#(
   parameter int OUT_W   = 24,
   parameter int PHASE_W = 32,
   parameter int VOL_W   = 7
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    load,
   input  logic [PHASE_W-1:0]      freq_word,
   input  logic [1:0]              mode,
   input  logic [7:0]              pulse_width,
   input  logic [VOL_W-1:0]        volume,
   output logic signed [OUT_W-1:0] value,
   output logic                    wrap
);

   localparam int PROD_W = OUT_W + VOL_W + 1;
   localparam logic signed [OUT_W-1:0] MAXP = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] NEGP = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

   logic [PHASE_W-1:0]      phase_q, phase_d;
   logic [PHASE_W-1:0]      actFreq_q, pendFreq_q;
   wave_mode_t              actMode_q, pendMode_q;
   logic [7:0]              actPw_q, pendPw_q;
   logic                    pendValid_q;
   logic [PHASE_W:0]        phaseSum;
   logic                    wrapEvt, applyPend;
   logic [15:0]             lfsrOut;
   logic [OUT_W-1:0]        sawU, triU, triF;
   logic signed [OUT_W-1:0] raw_q, raw_d, value_q, value_d;
   logic signed [PROD_W-1:0] rawExt, volExt, prod;
   logic                    wrapP_q, wrapR_q, wrap_q;

   // Pending values land on a wrap, or at once when the phase is not moving
   assign phaseSum  = {1'b0, phase_q} + {1'b0, actFreq_q};
   assign wrapEvt   = enable & phaseSum[PHASE_W];
   assign applyPend = pendValid_q & (wrapEvt | ~enable | (actFreq_q == '0));
   assign phase_d   = enable ? phaseSum[PHASE_W-1:0] : '0;

   wave_lfsr16 uLfsr (
      .clk   (clk),
      .reset (reset),
      .step  (wrapEvt),
      .out   (lfsrOut)
   );

   // Waveform shaping from the current phase; triangle folds the top half
   always_comb begin
      sawU  = phase_q[PHASE_W-1 -: OUT_W];
      triU  = phase_q[PHASE_W-2 -: OUT_W];
      triF  = phase_q[PHASE_W-1] ? ~triU : triU;
      raw_d = '0;
      if (enable) begin
         case (actMode_q)
            SAW:     raw_d = {~sawU[OUT_W-1], sawU[OUT_W-2:0]};
            TRI:     raw_d = {~triF[OUT_W-1], triF[OUT_W-2:0]};
            PULSE:   raw_d = (phase_q[PHASE_W-1 -: 8] < actPw_q) ? MAXP : NEGP;
            NOISE:   raw_d[OUT_W-1 -: 16] = lfsrOut;
            default: raw_d = '0;
         endcase
      end
   end

   // Signed sample times unsigned gain, floor-divided by 2^VOL_W
   always_comb begin
      rawExt  = {{(VOL_W+1){raw_q[OUT_W-1]}}, raw_q};
      volExt  = {{(OUT_W+1){1'b0}}, volume};
      prod    = rawExt * volExt;
      value_d = (volume == '1) ? raw_q : prod[OUT_W+VOL_W-1 : VOL_W];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q     <= '0;
         actFreq_q   <= '0;
         actMode_q   <= SAW;
         actPw_q     <= '0;
         pendFreq_q  <= '0;
         pendMode_q  <= SAW;
         pendPw_q    <= '0;
         pendValid_q <= 1'b0;
         raw_q       <= '0;
         value_q     <= '0;
         wrapP_q     <= 1'b0;
         wrapR_q     <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         phase_q <= phase_d;
         if (applyPend) begin
            actFreq_q <= pendFreq_q;
            actMode_q <= pendMode_q;
            actPw_q   <= pendPw_q;
         end
         if (load) begin
            pendFreq_q  <= freq_word;
            pendMode_q  <= wave_mode_t'(mode);
            pendPw_q    <= pulse_width;
            pendValid_q <= 1'b1;
         end else if (applyPend) begin
            pendValid_q <= 1'b0;
         end
         raw_q   <= raw_d;
         value_q <= value_d;
         wrapP_q <= wrapEvt;
         wrapR_q <= wrapP_q;
         wrap_q  <= wrapR_q;
      end
   end

   assign value = value_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_multi_wave_oscillator.sv
// Self-checking bench for multi_wave_oscillator: arithmetic reference model
// compared every cycle, plus directed literal checkpoints.
module tb_multi_wave_oscillator;

   localparam int OUT_W   = 24;
   localparam int PHASE_W = 32;
   localparam int VOL_W   = 7;
   localparam longint TWO32 = 64'sd4294967296;
   localparam longint TWO31 = 64'sd2147483648;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    enable = 1'b0;
   logic                    load = 1'b0;
   logic [PHASE_W-1:0]      freqWord = '0;
   logic [1:0]              mode = '0;
   logic [7:0]              pulseWidth = '0;
   logic [VOL_W-1:0]        volume = 7'd127;
   logic signed [OUT_W-1:0] value;
   logic                    wrap;

   int assertCount = 0;
   int failCount   = 0;
   bit checkOn     = 1'b0;

   multi_wave_oscillator #(.OUT_W(OUT_W), .PHASE_W(PHASE_W), .VOL_W(VOL_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .load        (load),
      .freq_word   (freqWord),
      .mode        (mode),
      .pulse_width (pulseWidth),
      .volume      (volume),
      .value       (value),
      .wrap        (wrap)
   );

   always #5 clk = ~clk;

   // Reference model: waveform formulas written as plain integer arithmetic
   longint mPhase = 0, mActF = 0, mPendF = 0;
   int     mActMode = 0, mPendMode = 0, mActPw = 0, mPendPw = 0;
   bit     mPendV = 1'b0;
   int     mLfsr = 16'hACE1;
   int     mRaw = 0, mValue = 0;
   bit     w1 = 1'b0, w2 = 1'b0, mWrap = 1'b0;

   function automatic int waveOf(input longint p, input int m, input int pw, input int l);
      case (m)
         0: return int'(p / 256) - 8388608;
         1: return (p < TWO31) ? int'(p / 128) - 8388608 : 8388607 - int'((p - TWO31) / 128);
         2: return (int'(p / 16777216) < pw) ? 8388607 : -8388607;
         default: return (l >= 32768) ? l * 256 - 16777216 : l * 256;
      endcase
   endfunction

   function automatic int scaleOf(input int r, input int v);
      longint pr, q;
      if (v == 127) return r;
      pr = longint'(r) * v;
      q  = pr / 128;
      if ((pr % 128 != 0) && (pr < 0)) q = q - 1;
      return int'(q);
   endfunction

   function automatic int lfsrNext(input int l);
      int fb;
      fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
      return ((l << 1) | fb) & 16'hFFFF;
   endfunction

   always @(posedge clk) begin
      longint sum;
      bit     wrapNow, applyNow;
      int     newRaw;
      if (reset) begin
         mPhase = 0; mActF = 0; mPendF = 0;
         mActMode = 0; mPendMode = 0; mActPw = 0; mPendPw = 0;
         mPendV = 1'b0; mLfsr = 16'hACE1; mRaw = 0; mValue = 0;
         w1 = 1'b0; w2 = 1'b0; mWrap = 1'b0;
      end else begin
         sum      = mPhase + mActF;
         wrapNow  = enable && (sum >= TWO32);
         newRaw   = enable ? waveOf(mPhase, mActMode, mActPw, mLfsr) : 0;
         mValue   = scaleOf(mRaw, int'(volume));
         mRaw     = newRaw;
         mWrap    = w2;
         w2       = w1;
         w1       = wrapNow;
         applyNow = mPendV && (wrapNow || !enable || mActF == 0);
         if (wrapNow) mLfsr = lfsrNext(mLfsr);
         mPhase = enable ? (sum % TWO32) : 0;
         if (applyNow) begin
            mActF = mPendF; mActMode = mPendMode; mActPw = mPendPw;
         end
         if (load) begin
            mPendF = longint'(freqWord); mPendMode = int'(mode);
            mPendPw = int'(pulseWidth); mPendV = 1'b1;
         end else if (applyNow) begin
            mPendV = 1'b0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (checkOn) begin
         assertCount++;
         if (int'(value) !== mValue) begin
            failCount++;
            $display("[TB] FAIL model.value t=%0t: got %0d, required %0d", $time, value, mValue);
         end
         assertCount++;
         if (wrap !== mWrap) begin
            failCount++;
            $display("[TB] FAIL model.wrap t=%0t: got %0b, required %0b", $time, wrap, mWrap);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ld, input logic [31:0] f, input logic [1:0] m,
                                input logic [7:0] pw);
      load       = ld;
      freqWord   = f;
      mode       = m;
      pulseWidth = pw;
   endtask

   task automatic checkOutput(input string name, input int expV, input bit expW);
      assertCount++;
      if (int'(value) !== expV) begin
         failCount++;
         $display("[TB] FAIL %s value: got %0d, required %0d", name, value, expV);
      end
      assertCount++;
      if (wrap !== expW) begin
         failCount++;
         $display("[TB] FAIL %s wrap: got %0b, required %0b", name, wrap, expW);
      end
   endtask

   // Stop the phase, stage new settings (applied at once), then re-enable
   task automatic restart(input logic [31:0] f, input logic [1:0] m, input logic [7:0] pw);
      enable = 1'b0;
      applyStimulus(1'b1, f, m, pw);
      tick(1);
      load = 1'b0;
      tick(1);
      enable = 1'b1;
   endtask

   initial begin
      tick(1);
      checkOn = 1'b1;
      tick(1);
      checkOutput("reset", 0, 1'b0);
      reset = 1'b0;

      $display("[TB] saw");
      volume = 7'd127;
      restart(32'h1000_0000, 2'd0, 8'd0);
      tick(2);  checkOutput("saw0", -8388608, 1'b0);
      tick(1);  checkOutput("saw1", -7340032, 1'b0);
      tick(15); checkOutput("sawWrap", -8388608, 1'b1);

      $display("[TB] triangle");
      restart(32'h1000_0000, 2'd1, 8'd0);
      tick(2); checkOutput("tri0", -8388608, 1'b0);
      tick(4); checkOutput("tri4", 0, 1'b0);
      tick(4); checkOutput("tri8", 8388607, 1'b0);
      tick(1); checkOutput("tri9", 6291455, 1'b0);

      $display("[TB] pulse");
      volume = 7'd64;
      restart(32'h1000_0000, 2'd2, 8'd128);
      tick(2); checkOutput("pulseHi", 4194303, 1'b0);
      tick(8); checkOutput("pulseLo", -4194304, 1'b0);
      tick(8); checkOutput("pulseWrap", 4194303, 1'b1);
      volume = 7'd127;
      restart(32'h1000_0000, 2'd2, 8'd0);
      tick(2); checkOutput("pw0a", -8388607, 1'b0);
      tick(5); checkOutput("pw0b", -8388607, 1'b0);

      $display("[TB] staged loads");
      restart(32'h1000_0000, 2'd0, 8'd0);
      tick(4);
      applyStimulus(1'b1, 32'h2000_0000, 2'd0, 8'd0);
      tick(1);  load = 1'b0;
      tick(12); checkOutput("midOld", 7340032, 1'b0);
      tick(1);  checkOutput("midWrap", -8388608, 1'b1);
      tick(1);  checkOutput("midNewRate", -6291456, 1'b0);
      tick(7);  checkOutput("midWrap2", -8388608, 1'b1);
      tick(1);
      applyStimulus(1'b1, 32'h0800_0000, 2'd1, 8'd0);
      tick(1);
      applyStimulus(1'b1, 32'h4000_0000, 2'd0, 8'd0);
      tick(1); load = 1'b0;
      tick(5); checkOutput("dblWrap", -8388608, 1'b1);
      tick(1); checkOutput("dblRate", -4194304, 1'b0);
      tick(3); checkOutput("dblWrap2", -8388608, 1'b1);

      $display("[TB] load while frozen");
      restart(32'h0000_0000, 2'd0, 8'd0);
      tick(2);
      applyStimulus(1'b1, 32'h1000_0000, 2'd0, 8'd0);
      tick(1); load = 1'b0;
      tick(3); checkOutput("f0hold", -8388608, 1'b0);
      tick(1); checkOutput("f0go", -7340032, 1'b0);

      $display("[TB] reset mid-run and noise");
      tick(3);
      reset = 1'b1;
      applyStimulus(1'b1, 32'h2000_0000, 2'd1, 8'd7);
      tick(1); checkOutput("rstMid", 0, 1'b0);
      reset = 1'b0;
      load  = 1'b0;
      restart(32'h1000_0000, 2'd3, 8'd0);
      tick(2);  checkOutput("noise0", -5447424, 1'b0);
      tick(15); checkOutput("noisePre", -5447424, 1'b0);
      tick(1);  checkOutput("noiseWrap", 5882624, 1'b1);

      $display("[TB] disable");
      enable = 1'b0;
      tick(2); checkOutput("disable", 0, 1'b0);
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
